// File: rtl/alu_share_arb_pkg.sv
// Shared ALU definitions: data width, aluc opcode constants and the operand bundle
// carried from the arbiter into the ALU stage.
package alu_share_arb_pkg;

  localparam int DW = 32;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    aluc;
  } alu_op_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts move b by a[4:0], LUI places b[15:0] in the upper half.
// Bit 3 of aluc is a don't-care except to separate SRA from SRL.
module alu
  import alu_share_arb_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    aluc,
  output logic [DW-1:0] r,
  output logic          z
);

  always_comb begin
    r = '0;
    casez (aluc)
      4'b?000: r = a + b;
      4'b?100: r = a - b;
      4'b?001: r = a & b;
      4'b?101: r = a | b;
      4'b?010: r = a ^ b;
      4'b?110: r = {b[15:0], 16'h0000};
      4'b?011: r = b << a[4:0];
      4'b0111: r = b >> a[4:0];
      4'b1111: r = $signed(b) >>> a[4:0];
      default: r = '0;
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/alu_share_arb_rr.sv
// Round-robin arbiter: combinational one-hot grant searching from ptr+1, ptr moves to
// the winner when advance is high; reset points ptr at the last requester.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id
);

  logic [IDW-1:0] ptr;

  // Each requester's distance from ptr+1 is unique, so the smallest valid one wins.
  always_comb begin
    int best;
    int d;
    best     = NREQ;
    d        = 0;
    grant    = '0;
    grant_id = '0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - 1 - int'(ptr)) % NREQ;
      if (req[i] && d < best) begin
        best     = d;
        grant    = '0;
        grant[i] = 1'b1;
        grant_id = IDW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn)
      ptr <= IDW'(NREQ - 1);
    else if (advance)
      ptr <= grant_id;
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU among NREQ requesters: round-robin grant, operand register, registered
// result tagged with the owner's id two cycles after acceptance; never stalls.
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  input  logic [NREQ*4-1:0]  req_aluc,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_r,
  output logic               rsp_z,
  output logic [15:0]        op_count
);

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            xfer;
  alu_op_t         sel_op;
  alu_op_t         s1_op;
  logic            s1_valid;
  logic [IDW-1:0]  s1_id;
  logic [DW-1:0]   alu_r;
  logic            alu_z;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk      (clk),
    .clrn     (clrn),
    .req      (req_valid),
    .advance  (xfer),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_ready = clrn ? grant : '0;
  assign xfer      = |(req_valid & req_ready);

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_op.a    = req_a[DW*i +: DW];
        sel_op.b    = req_b[DW*i +: DW];
        sel_op.aluc = req_aluc[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_id    <= '0;
      op_count <= '0;
    end else begin
      s1_valid <= xfer;
      if (xfer) begin
        s1_op    <= sel_op;
        s1_id    <= grant_id;
        op_count <= op_count + 16'd1;
      end
    end
  end

  alu u_alu (
    .a    (s1_op.a),
    .b    (s1_op.b),
    .aluc (s1_op.aluc),
    .r    (alu_r),
    .z    (alu_z)
  );

  // Result fields hold between responses so requesters may read them late.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      rsp_valid <= 1'b0;
      rsp_r     <= '0;
      rsp_z     <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_r  <= alu_r;
        rsp_z  <= alu_z;
        rsp_id <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus random traffic, every cycle compared
// against a queue-based reference of grants, results and the operation count.
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                clk = 1'b0;
  logic                clrn;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*32-1:0]  req_a;
  logic [NREQ*32-1:0]  req_b;
  logic [NREQ*4-1:0]   req_aluc;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [31:0]         rsp_r;
  logic                rsp_z;
  logic [15:0]         op_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_aluc  (req_aluc),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_r     (rsp_r),
    .rsp_z     (rsp_z),
    .op_count  (op_count)
  );

  typedef struct {
    int          due;
    int          id;
    logic [31:0] r;
  } exp_t;

  exp_t        pend[$];
  int          m_ptr;
  int          m_cnt;
  int          cyc;
  logic [31:0] last_r;
  int          last_id;
  logic        last_z;

  logic [31:0] op_a[NREQ];
  logic [31:0] op_b[NREQ];
  logic [3:0]  op_c[NREQ];

  logic [NREQ-1:0] obs_rdy;
  logic            obs_rv;
  logic [IDW-1:0]  obs_id;
  logic [31:0]     obs_r;
  logic            obs_z;
  logic [15:0]     obs_cnt;

  logic [3:0] legal_ops[9] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
                               ALU_LUI, ALU_SLL, ALU_SRL, ALU_SRA};

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_LUI: return {b[15:0], 16'h0000};
      ALU_SLL: return b << a[4:0];
      ALU_SRL: return b >> a[4:0];
      ALU_SRA: return $signed(b) >>> a[4:0];
      default: return 32'h0;
    endcase
  endfunction

  // One clock cycle: drive, compare against the reference, advance the reference.
  task automatic step(input logic rstn, input logic [NREQ-1:0] v);
    int              g;
    exp_t            e;
    logic [NREQ-1:0] exp_rdy;
    clrn      = rstn;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32]  = op_a[i];
      req_b[32*i +: 32]  = op_b[i];
      req_aluc[4*i +: 4] = op_c[i];
    end
    #1;
    g = -1;
    if (rstn)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = req_ready; obs_rv = rsp_valid; obs_id = rsp_id;
    obs_r = rsp_r; obs_z = rsp_z; obs_cnt = op_count;

    n_checks++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL grant cyc=%0d: req_ready=%b expected %b", cyc, req_ready, exp_rdy);
    end
    n_checks++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      last_r = e.r; last_id = e.id; last_z = (e.r == 32'h0);
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e.id) || rsp_r !== e.r || rsp_z !== last_z) begin
        n_fail++;
        $display("FAIL rsp cyc=%0d: got v=%b id=%0d r=%h z=%b, expected v=1 id=%0d r=%h z=%b",
                 cyc, rsp_valid, rsp_id, rsp_r, rsp_z, e.id, e.r, last_z);
      end
    end else if (rsp_valid !== 1'b0 || rsp_id !== IDW'(last_id) || rsp_r !== last_r || rsp_z !== last_z) begin
      n_fail++;
      $display("FAIL rsp_idle cyc=%0d: got v=%b id=%0d r=%h z=%b, expected v=0 id=%0d r=%h z=%b",
               cyc, rsp_valid, rsp_id, rsp_r, rsp_z, last_id, last_r, last_z);
    end
    n_checks++;
    if (op_count !== 16'(m_cnt)) begin
      n_fail++;
      $display("FAIL op_count cyc=%0d: got %0d expected %0d", cyc, op_count, m_cnt);
    end

    if (!rstn) begin
      pend.delete();
      last_r = 32'h0; last_id = 0; last_z = 1'b0;
      m_ptr = NREQ - 1; m_cnt = 0;
    end else if (g >= 0) begin
      pend.push_back('{cyc + 2, g, ref_alu(op_c[g], op_a[g], op_b[g])});
      m_ptr = g;
      m_cnt = (m_cnt + 1) % 65536;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = $urandom;
      op_b[i] = $urandom;
      op_c[i] = legal_ops[$urandom_range(0, 8)];
    end
  endtask

  task automatic test_reset();
    rand_ops();
    step(1'b0, '1);
    n_checks++;
    if (obs_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", obs_rdy); end
    step(1'b0, '1);
    step(1'b1, '0);
    n_checks++;
    if (obs_rv !== 1'b0 || obs_r !== 32'h0 || obs_z !== 1'b0 || obs_id !== 1'b0 || obs_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b r=%h z=%b id=%0d cnt=%0d expected all 0", obs_rv, obs_r, obs_z, obs_id, obs_cnt);
    end
  endtask

  task automatic test_simple_add();
    op_a[0] = 32'd1; op_b[0] = 32'd2; op_c[0] = ALU_ADD;
    step(1'b1, 2'b01);
    n_checks++;
    if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL add_ready: got %b expected 01", obs_rdy); end
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_id !== 1'b0 || obs_r !== 32'h3 || obs_z !== 1'b0 || obs_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL add_rsp: v=%b id=%0d r=%h z=%b cnt=%0d expected 1 0 00000003 0 1", obs_rv, obs_id, obs_r, obs_z, obs_cnt);
    end
  endtask

  task automatic test_contention();
    step(1'b0, 2'b00);
    op_a[0] = 32'hffffffff; op_b[0] = 32'hffffffff; op_c[0] = ALU_SUB;
    op_a[1] = 32'hcccccccc; op_b[1] = 32'haaaaaaaa; op_c[1] = ALU_AND;
    step(1'b1, 2'b11);
    n_checks++;
    if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL cont_first: got %b expected 01", obs_rdy); end
    step(1'b1, 2'b10);
    n_checks++;
    if (obs_rdy !== 2'b10) begin n_fail++; $display("FAIL cont_second: got %b expected 10", obs_rdy); end
    step(1'b1, 2'b00);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_id !== 1'b0 || obs_r !== 32'h0 || obs_z !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_rsp0: v=%b id=%0d r=%h z=%b expected 1 0 00000000 1", obs_rv, obs_id, obs_r, obs_z);
    end
    step(1'b1, 2'b00);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_id !== 1'b1 || obs_r !== 32'h88888888 || obs_z !== 1'b0) begin
      n_fail++;
      $display("FAIL cont_rsp1: v=%b id=%0d r=%h z=%b expected 1 1 88888888 0", obs_rv, obs_id, obs_r, obs_z);
    end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    step(1'b0, 2'b00);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      step(1'b1, 2'b11);
      n_checks++;
      if (obs_rdy !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rotate[%0d]: got %b expected %b", i, obs_rdy, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      if (i >= 2 && obs_rv === 1'b1) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00);
      if (i < 2 && obs_rv === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 8 || obs_cnt !== 16'd8) begin
      n_fail++;
      $display("FAIL sustained: pulses=%0d op_count=%0d expected 8 8", pulses, obs_cnt);
    end
  endtask

  task automatic test_shifts();
    op_a[1] = 32'd16; op_b[1] = 32'hffffff00; op_c[1] = ALU_SRA;
    step(1'b1, 2'b10);
    op_a[1] = 32'd15; op_b[1] = 32'hffffffff; op_c[1] = ALU_SRL;
    step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_id !== 1'b1 || obs_r !== 32'hffffffff) begin
      n_fail++;
      $display("FAIL sra: v=%b id=%0d r=%h expected 1 1 ffffffff", obs_rv, obs_id, obs_r);
    end
    step(1'b1, 2'b00);
    n_checks++;
    if (obs_rv !== 1'b1 || obs_id !== 1'b1 || obs_r !== 32'h0001ffff) begin
      n_fail++;
      $display("FAIL srl: v=%b id=%0d r=%h expected 1 1 0001ffff", obs_rv, obs_id, obs_r);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    seen = 0;
    rand_ops();
    step(1'b1, 2'b01);
    step(1'b0, 2'b11);
    n_checks++;
    if (obs_rdy !== 2'b00) begin n_fail++; $display("FAIL mid_ready: got %b expected 00", obs_rdy); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00);
      if (obs_rv === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0 || obs_r !== 32'h0 || obs_cnt !== 16'h0) begin
      n_fail++;
      $display("FAIL mid_flush: pulses=%0d r=%h cnt=%0d expected 0 0 0", seen, obs_r, obs_cnt);
    end
    step(1'b1, 2'b11);
    n_checks++;
    if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL mid_first: got %b expected 01", obs_rdy); end
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rand_ops();
      step(($urandom_range(0, 49) != 0), NREQ'($urandom_range(0, 3)));
    end
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
  endtask

  task automatic test_counter_wrap();
    int id1_rsp;
    int total;
    id1_rsp = 0;
    total   = 0;
    step(1'b0, 2'b00);
    for (int n = 0; n < 65536; n++) begin
      op_a[0] = $urandom; op_b[0] = $urandom; op_c[0] = legal_ops[n % 9];
      step(1'b1, 2'b01);
    end
    step(1'b1, 2'b00);
    n_checks++;
    if (obs_cnt !== 16'h0) begin n_fail++; $display("FAIL wrap: op_count=%0d expected 0", obs_cnt); end
    step(1'b1, 2'b00);
    step(1'b1, 2'b00);
    rand_ops();
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    step(1'b1, 2'b01);
    n_checks++;
    if (obs_rdy !== 2'b01) begin n_fail++; $display("FAIL withdraw_ready: got %b expected 01", obs_rdy); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b00);
      if (obs_rv === 1'b1) begin
        total++;
        if (obs_id === 1'b1) id1_rsp++;
      end
    end
    n_checks++;
    if (id1_rsp != 0 || total != 2) begin
      n_fail++;
      $display("FAIL withdraw: id1 responses=%0d total=%0d expected 0 2", id1_rsp, total);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clrn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_aluc = '0;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; op_c[i] = '0; end
    m_ptr = NREQ - 1; m_cnt = 0; cyc = 0;
    last_r = 32'h0; last_id = 0; last_z = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_simple_add();
    test_contention();
    test_back_to_back();
    test_shifts();
    test_reset_midflight();
    test_random();
    test_counter_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
